mcu_branch_predictor_gshare: RTL and testbench

//  Parametrised gshare direction predictor for the MCU fetch stage; successor to the fixed 64-entry 2-bit BHT.
//  PHT of CTR_BITS saturating counters indexed by PC XOR global history (or PC only when USE_GSHARE=0).

---
 rtl/mcu_bp_pkg.sv | 35 +++
 rtl/mcu_bp_pht.sv | 49 ++++
 rtl/mcu_branch_predictor_gshare.sv | 121 ++++++++++++
 tb/tb_mcu_branch_predictor_gshare.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_bp_pkg.sv
// Shared types and counter helpers for the gshare direction predictor.
// Latency: pure combinational functions, no state.
// Backpressure: none; values are consumed by the PHT and the top-level FSM.
package mcu_bp_pkg;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    // Widest supported counter; narrower counters are carried zero-extended.
    localparam int CTR_MAX_W = 4;

    function automatic logic [CTR_MAX_W-1:0] wnt_value(input int ctr_bits);
        return CTR_MAX_W'((1 << (ctr_bits - 1)) - 1);
    endfunction

    function automatic logic [CTR_MAX_W-1:0] sat_update(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int                   ctr_bits
    );
        logic [CTR_MAX_W-1:0] top;
        logic [CTR_MAX_W-1:0] res;
        top = CTR_MAX_W'((1 << ctr_bits) - 1);
        res = ctr;
        if (taken) begin
            if (ctr != top) res = ctr + 4'd1;
        end else begin
            if (ctr != '0) res = ctr - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mcu_bp_pht.sv
// Pattern history table: ENTRIES saturating counters, async read, sync read-modify-write port.
// Latency: read is combinational; a write lands at the next clk edge.
// Backpressure: none; the sweep owns the write port in BP_INIT, resolved branches own it in BP_RUN.
module mcu_bp_pht
    import mcu_bp_pkg::*;
#(
    parameter int ENTRIES  = 256,
    parameter int CTR_BITS = 2,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  bp_state_e           state,
    input  logic [IDX_W-1:0]    init_ptr,
    input  logic                upd_en,
    input  logic [IDX_W-1:0]    upd_idx,
    input  logic                upd_taken,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr
);

    logic [CTR_BITS-1:0]  mem [ENTRIES];
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [CTR_BITS-1:0]  wr_dat;
    logic [CTR_MAX_W-1:0] upd_old;

    assign upd_old = CTR_MAX_W'(mem[upd_idx]);

    // The sweep takes priority so nothing trains a counter before it is initialised.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = init_ptr;
        wr_dat = CTR_BITS'(wnt_value(CTR_BITS));
        if (state == BP_INIT) begin
            wr_en = 1'b1;
        end else if (upd_en) begin
            wr_en  = 1'b1;
            wr_idx = upd_idx;
            wr_dat = CTR_BITS'(sat_update(upd_old, upd_taken, CTR_BITS));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_dat;
    end

    assign rd_ctr = mem[rd_idx];

endmodule

// File: rtl/mcu_branch_predictor_gshare.sv
// Gshare/bimodal branch direction predictor with speculative global history and post-reset PHT sweep.
// Latency: prediction is combinational from pc_fetch; training and history updates take effect next edge.
// Backpressure: none; fetch/update inputs are ignored until init_done rises.
module mcu_branch_predictor_gshare
    import mcu_bp_pkg::*;
#(
    parameter int ENTRIES    = 256,
    parameter int GHR_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int PC_LSB     = 2,
    parameter int USE_GSHARE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                init_done,
    input  logic                fetch_valid,
    input  logic [31:0]         pc_fetch,
    output logic                predict_taken,
    output logic [GHR_BITS-1:0] predict_ghr,
    input  logic                update_valid,
    input  logic [31:0]         update_pc,
    input  logic [GHR_BITS-1:0] update_ghr,
    input  logic                update_taken,
    input  logic                update_mispredict
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_state_e           state;
    bp_state_e           state_nxt;
    logic [IDX_W-1:0]    init_ptr;
    logic                init_last;
    logic                running;
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] ghr_nxt;
    logic [GHR_BITS-1:0] ghr_spec;
    logic [GHR_BITS-1:0] ghr_fix;
    logic [IDX_W-1:0]    hist_f;
    logic [IDX_W-1:0]    hist_u;
    logic [IDX_W-1:0]    idx_f;
    logic [IDX_W-1:0]    idx_u;
    logic [CTR_BITS-1:0] ctr_f;
    logic                unused_bits;

    // History folded to index width: truncate long histories, zero-extend short ones.
    if (GHR_BITS >= IDX_W) begin : g_hist_trunc
        assign hist_f = ghr[IDX_W-1:0];
        assign hist_u = update_ghr[IDX_W-1:0];
    end else begin : g_hist_ext
        assign hist_f = {{(IDX_W-GHR_BITS){1'b0}}, ghr};
        assign hist_u = {{(IDX_W-GHR_BITS){1'b0}}, update_ghr};
    end

    if (GHR_BITS == 1) begin : g_ghr_one
        assign ghr_spec = predict_taken;
        assign ghr_fix  = update_taken;
    end else begin : g_ghr_shift
        assign ghr_spec = {ghr[GHR_BITS-2:0], predict_taken};
        assign ghr_fix  = {update_ghr[GHR_BITS-2:0], update_taken};
    end

    assign idx_f = pc_fetch[PC_LSB +: IDX_W] ^ ((USE_GSHARE != 0) ? hist_f : '0);
    assign idx_u = update_pc[PC_LSB +: IDX_W] ^ ((USE_GSHARE != 0) ? hist_u : '0);

    assign running   = (state == BP_RUN);
    assign init_last = (init_ptr == IDX_W'(ENTRIES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BP_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BP_INIT: if (init_last) state_nxt = BP_RUN;
            BP_RUN:  state_nxt = BP_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              init_ptr <= '0;
        else if (state == BP_INIT) init_ptr <= init_ptr + IDX_W'(1);
    end

    // A mispredict flushes younger fetches, so the restored history beats the speculative shift.
    always_comb begin
        ghr_nxt = ghr;
        if (running) begin
            if (update_valid && update_mispredict) ghr_nxt = ghr_fix;
            else if (fetch_valid)                  ghr_nxt = ghr_spec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr <= '0;
        else        ghr <= ghr_nxt;
    end

    mcu_bp_pht #(
        .ENTRIES  (ENTRIES),
        .CTR_BITS (CTR_BITS),
        .IDX_W    (IDX_W)
    ) u_pht (
        .clk       (clk),
        .state     (state),
        .init_ptr  (init_ptr),
        .upd_en    (update_valid),
        .upd_idx   (idx_u),
        .upd_taken (update_taken),
        .rd_idx    (idx_f),
        .rd_ctr    (ctr_f)
    );

    assign init_done     = running;
    assign predict_taken = running & ctr_f[CTR_BITS-1];
    assign predict_ghr   = ghr;

    assign unused_bits = ^{pc_fetch, update_pc, update_ghr};

endmodule

// File: tb/tb_mcu_branch_predictor_gshare.sv
// Self-checking bench: a gshare and a bimodal build driven in lockstep against an array-based model,
// plus directed sequences with literal expectations.
module tb_mcu_branch_predictor_gshare;

    localparam int ENTRIES  = 256;
    localparam int GHR_BITS = 8;
    localparam int CTR_BITS = 2;
    localparam int PC_LSB   = 2;
    localparam int CMAX     = (1 << CTR_BITS) - 1;
    localparam int WNT      = (1 << (CTR_BITS - 1)) - 1;
    localparam int THRESH   = 1 << (CTR_BITS - 1);
    localparam int GMASK    = (1 << GHR_BITS) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] pc_fetch = '0;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic [7:0]  update_ghr = '0;
    logic        update_taken = 1'b0;
    logic        update_mispredict = 1'b0;

    logic        dn_gs, dn_bm, pt_gs, pt_bm;
    logic [7:0]  pg_gs, pg_bm;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mcu_branch_predictor_gshare #(
        .ENTRIES(ENTRIES), .GHR_BITS(GHR_BITS), .CTR_BITS(CTR_BITS), .PC_LSB(PC_LSB), .USE_GSHARE(1)
    ) dut_gs (
        .clk(clk), .rst_n(rst_n), .init_done(dn_gs),
        .fetch_valid(fetch_valid), .pc_fetch(pc_fetch),
        .predict_taken(pt_gs), .predict_ghr(pg_gs),
        .update_valid(update_valid), .update_pc(update_pc), .update_ghr(update_ghr),
        .update_taken(update_taken), .update_mispredict(update_mispredict)
    );

    mcu_branch_predictor_gshare #(
        .ENTRIES(ENTRIES), .GHR_BITS(GHR_BITS), .CTR_BITS(CTR_BITS), .PC_LSB(PC_LSB), .USE_GSHARE(0)
    ) dut_bm (
        .clk(clk), .rst_n(rst_n), .init_done(dn_bm),
        .fetch_valid(fetch_valid), .pc_fetch(pc_fetch),
        .predict_taken(pt_bm), .predict_ghr(pg_bm),
        .update_valid(update_valid), .update_pc(update_pc), .update_ghr(update_ghr),
        .update_taken(update_taken), .update_mispredict(update_mispredict)
    );

    function automatic int act_done(input int g);
        return (g == 0) ? int'(dn_gs) : int'(dn_bm);
    endfunction
    function automatic int act_pred(input int g);
        return (g == 0) ? int'(pt_gs) : int'(pt_bm);
    endfunction
    function automatic int act_ghr(input int g);
        return (g == 0) ? int'(pg_gs) : int'(pg_bm);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: instance 0 is gshare, instance 1 bimodal. Counters are plain ints.
    int m_pht [2][ENTRIES];
    int m_ghr [2];
    int m_sweep = 0;
    bit m_run = 1'b0;
    bit m_p;
    int m_iu;

    function automatic int m_idx(input int g, input logic [31:0] pc, input int h);
        int base;
        base = int'(pc >> PC_LSB) & (ENTRIES - 1);
        return (g == 0) ? ((base ^ h) & (ENTRIES - 1)) : base;
    endfunction

    function automatic int m_pred(input int g);
        if (!m_run) return 0;
        return (m_pht[g][m_idx(g, pc_fetch, m_ghr[g])] >= THRESH) ? 1 : 0;
    endfunction

    initial begin
        m_ghr[0] = 0;
        m_ghr[1] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 1'b0;
                m_sweep = 0;
                m_ghr[0] = 0;
                m_ghr[1] = 0;
            end else if (!m_run) begin
                m_sweep++;
                if (m_sweep == ENTRIES) begin
                    m_run = 1'b1;
                    for (int g = 0; g < 2; g++)
                        for (int i = 0; i < ENTRIES; i++) m_pht[g][i] = WNT;
                end
            end else begin
                for (int g = 0; g < 2; g++) begin
                    m_p = (m_pred(g) != 0);
                    if (update_valid) begin
                        m_iu = m_idx(g, update_pc, int'(update_ghr));
                        if (update_taken) m_pht[g][m_iu] = (m_pht[g][m_iu] < CMAX) ? m_pht[g][m_iu] + 1 : CMAX;
                        else              m_pht[g][m_iu] = (m_pht[g][m_iu] > 0) ? m_pht[g][m_iu] - 1 : 0;
                    end
                    if (update_valid && update_mispredict)
                        m_ghr[g] = (2 * int'(update_ghr) + int'(update_taken)) & GMASK;
                    else if (fetch_valid)
                        m_ghr[g] = (2 * m_ghr[g] + int'(m_p)) & GMASK;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check($sformatf("cmp_init_done[%0d]", g), act_done(g), int'(m_run));
                check($sformatf("cmp_predict[%0d]", g), act_pred(g), m_pred(g));
                check($sformatf("cmp_ghr[%0d]", g), act_ghr(g), m_ghr[g]);
            end
        end
    end

    // Every task below starts and ends 1 time unit after a rising edge.
    task automatic sweep_check(input bit poke, input string tag);
        for (int k = 1; k <= ENTRIES; k++) begin
            @(posedge clk);
            #1;
            if (poke) begin
                fetch_valid       = (k < 250);
                pc_fetch          = 32'(k) << 2;
                update_valid      = (k < 250);
                update_pc         = 32'h100;
                update_ghr        = 8'hFF;
                update_taken      = 1'b1;
                update_mispredict = 1'b1;
            end
            @(negedge clk);
            if (k == ENTRIES - 1) begin
                check({tag, "_done_low_gs"}, int'(dn_gs), 0);
                check({tag, "_done_low_bm"}, int'(dn_bm), 0);
                check({tag, "_pred_init"}, int'(pt_gs | pt_bm), 0);
            end
            if (k == ENTRIES) begin
                check({tag, "_done_high_gs"}, int'(dn_gs), 1);
                check({tag, "_done_high_bm"}, int'(dn_bm), 1);
                check({tag, "_ghr_untouched"}, int'(pg_gs), 0);
            end
        end
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        update_valid = 1'b0;
        update_mispredict = 1'b0;
    endtask

    task automatic check_all_nt(input string tag);
        fetch_valid = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            pc_fetch = 32'(i) << PC_LSB;
            @(negedge clk);
            check($sformatf("%s_nt_gs[%0d]", tag, i), int'(pt_gs), 0);
            check($sformatf("%s_nt_bm[%0d]", tag, i), int'(pt_bm), 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic [7:0] h, input logic t, input logic misp);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_ghr        = h;
        update_taken      = t;
        update_mispredict = misp;
        @(posedge clk);
        #1;
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    task automatic probe(input bit fv, input logic [31:0] pc, input int p_gs, input int p_bm,
                         input int g_exp, input string name);
        fetch_valid = fv;
        pc_fetch    = pc;
        @(negedge clk);
        check({name, "_pred_gs"}, int'(pt_gs), p_gs);
        check({name, "_pred_bm"}, int'(pt_bm), p_bm);
        check({name, "_ghr_gs"}, int'(pg_gs), g_exp);
        check({name, "_ghr_bm"}, int'(pg_bm), g_exp);
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_done_gs"}, int'(dn_gs), 0);
        check({tag, "_done_bm"}, int'(dn_bm), 0);
        check({tag, "_pred"}, int'(pt_gs | pt_bm), 0);
        check({tag, "_ghr_gs"}, int'(pg_gs), 0);
        check({tag, "_ghr_bm"}, int'(pg_bm), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_in_reset("reset");
        rst_n = 1'b1;
        sweep_check(1'b1, "init");
        check_all_nt("post_init");

        // Training at one pc with zero history, then both saturation ends.
        repeat (2) upd(32'h100, 8'h00, 1'b1, 1'b0);
        probe(1'b0, 32'h100, 1, 1, 0, "train_t");
        repeat (3) upd(32'h100, 8'h00, 1'b0, 1'b0);
        probe(1'b0, 32'h100, 0, 0, 0, "train_nt");
        repeat (10) upd(32'h100, 8'h00, 1'b0, 1'b0);
        probe(1'b0, 32'h100, 0, 0, 0, "floor_hold");
        upd(32'h100, 8'h00, 1'b1, 1'b0);
        probe(1'b0, 32'h100, 0, 0, 0, "floor_step1");
        upd(32'h100, 8'h00, 1'b1, 1'b0);
        probe(1'b0, 32'h100, 1, 1, 0, "floor_step2");
        repeat (5) upd(32'h180, 8'h00, 1'b1, 1'b0);
        upd(32'h180, 8'h00, 1'b0, 1'b0);
        probe(1'b0, 32'h180, 1, 1, 0, "ceiling_hold");

        // Speculative history: T, T, NT from ghr 0 gives 3'b110.
        repeat (2) upd(32'h200, 8'h00, 1'b1, 1'b0);
        repeat (2) upd(32'h300, 8'h01, 1'b1, 1'b0);
        probe(1'b1, 32'h200, 1, 1, 8'h00, "spec0");
        probe(1'b1, 32'h300, 1, 1, 8'h01, "spec1");
        probe(1'b1, 32'h400, 0, 0, 8'h03, "spec2");
        probe(1'b0, 32'h400, 0, 0, 8'h06, "spec_end");

        // Restore beats a same-cycle fetch shift.
        fetch_valid = 1'b1;
        pc_fetch    = 32'h600;
        upd(32'h500, 8'hA5, 1'b1, 1'b1);
        fetch_valid = 1'b0;
        probe(1'b0, 32'h600, 0, 1, 8'h4B, "restore_wins");

        // History sensitivity: gshare depends on ghr, bimodal does not.
        repeat (2) upd(32'h40, 8'h03, 1'b1, 1'b0);
        upd(32'hFFC, 8'h00, 1'b0, 1'b1);
        probe(1'b0, 32'h40, 0, 1, 8'h00, "hist_ghr0");
        upd(32'hFFC, 8'h01, 1'b1, 1'b1);
        probe(1'b0, 32'h40, 1, 1, 8'h03, "hist_ghr3");

        for (int c = 0; c < 3000; c++) begin
            fetch_valid       = 1'($urandom_range(0, 1));
            pc_fetch          = (32'($urandom_range(0, 63)) << 2) | ($urandom & 32'hFFFF_F003);
            update_valid      = ($urandom_range(0, 2) != 0);
            update_pc         = (32'($urandom_range(0, 63)) << 2) | ($urandom & 32'hFFFF_F003);
            update_ghr        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            update_taken      = 1'($urandom_range(0, 1));
            update_mispredict = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
        end
        fetch_valid = 1'b0;
        update_valid = 1'b0;
        update_mispredict = 1'b0;

        // Reset from live operation, then again part-way through the sweep.
        rst_n = 1'b0;
        #1;
        check_in_reset("run_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_in_reset("mid_sweep_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_check(1'b0, "resweep");
        check_all_nt("post_resweep");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
